// File: rtl/controlador_contador_t.sv
// Sequencer for a WIDTH-bit ripple counter built from negedge-toggling T stages.
// Clears/presets the bank, pulses it up to a target and checks every step.
module controlador_contador_t #(
    parameter int WIDTH         = 4,
    parameter int PULSE_LOW     = 1,
    parameter int PULSE_HIGH    = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             ff_clk,
    output logic             ff_reset,
    output logic [WIDTH-1:0] ff_preset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] cur_count
);

    localparam int PULSE_MAX = (PULSE_LOW > PULSE_HIGH) ? PULSE_LOW : PULSE_HIGH;
    localparam int MAX_LEN   = (PULSE_MAX > SETTLE_CYCLES) ? PULSE_MAX : SETTLE_CYCLES;
    localparam int TW        = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

    localparam logic [TW-1:0] SETTLE_LEN = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] LO_LEN     = TW'(PULSE_LOW - 1);
    localparam logic [TW-1:0] HI_LEN     = TW'(PULSE_HIGH - 1);

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        LOAD,
        SETTLE,
        CHECK,
        PULSE_LO,
        PULSE_HI,
        DONE,
        ERROR
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [WIDTH-1:0]  cur_count_q, cur_count_d;
    logic [WIDTH-1:0]  target_q, target_d;
    logic [WIDTH-1:0]  load_val_q, load_val_d;
    logic              load_q, load_d;
    logic [WIDTH-1:0]  sync1_q, sync2_q;

    logic              ff_clk_q, ff_clk_d;
    logic              ff_reset_q, ff_reset_d;
    logic [WIDTH-1:0]  ff_preset_q, ff_preset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    // State register, synchroniser and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            cur_count_q <= '0;
            target_q    <= '0;
            load_val_q  <= '0;
            load_q      <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            ff_clk_q    <= 1'b1;
            ff_reset_q  <= 1'b0;
            ff_preset_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cur_count_q <= cur_count_d;
            target_q    <= target_d;
            load_val_q  <= load_val_d;
            load_q      <= load_d;
            sync1_q     <= cnt_q;
            sync2_q     <= sync1_q;
            ff_clk_q    <= ff_clk_d;
            ff_reset_q  <= ff_reset_d;
            ff_preset_q <= ff_preset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Next-state logic; abort pre-empts every busy state.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path is left unassigned (no latches).
        state_d     = state_q;
        timer_d     = timer_q;
        cur_count_d = cur_count_q;
        target_d    = target_q;
        load_val_d  = load_val_q;
        load_d      = load_q;

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        target_d   = target;
                        load_val_d = load_val;
                        load_d     = load;
                        state_d    = CLEAR;
                    end
                end
                CLEAR: begin
                    cur_count_d = '0;
                    if (load_q) begin
                        state_d = LOAD;
                    end else begin
                        state_d = SETTLE;
                        timer_d = SETTLE_LEN;
                    end
                end
                LOAD: begin
                    cur_count_d = load_val_q;
                    state_d     = SETTLE;
                    timer_d     = SETTLE_LEN;
                end
                SETTLE: begin
                    if (timer_q == '0) state_d = CHECK;
                    else               timer_d = timer_q - 1'b1;
                end
                CHECK: begin
                    if (sync2_q != cur_count_q) begin
                        state_d = ERROR;
                    end else if (cur_count_q == target_q) begin
                        state_d = DONE;
                    end else begin
                        // The falling edge on entry is the toggle, so the shadow advances here.
                        state_d     = PULSE_LO;
                        timer_d     = LO_LEN;
                        cur_count_d = cur_count_q + WIDTH'(1);
                    end
                end
                PULSE_LO: begin
                    if (timer_q == '0) begin
                        state_d = PULSE_HI;
                        timer_d = HI_LEN;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                PULSE_HI: begin
                    if (timer_q == '0) begin
                        state_d = SETTLE;
                        timer_d = SETTLE_LEN;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                ERROR:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: decoded from the next state so the registered outputs line up with it.
    always_comb begin
        ff_clk_d    = (state_d != PULSE_LO);
        ff_reset_d  = (state_d == CLEAR);
        ff_preset_d = (state_d == LOAD) ? load_val_d : '0;
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        error_d     = error_q;
        if (state_q == IDLE && start) begin
            error_d = 1'b0;
        end else if (state_q == ERROR && !abort) begin
            error_d = 1'b1;
        end
    end

    assign ff_clk    = ff_clk_q;
    assign ff_reset  = ff_reset_q;
    assign ff_preset = ff_preset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cur_count = cur_count_q;

endmodule

// File: tb/tb_controlador_contador_t.sv
// Bench for controlador_contador_t: behavioural ripple bank plus an arithmetic
// model of pulse count, cycle budget and first failing step.
module tb_controlador_contador_t;

    localparam int WIDTH = 4;
    localparam int PL    = 1;
    localparam int PH    = 1;
    localparam int SC    = 4;
    localparam int STEP  = PL + PH + SC + 1;

    logic             clk = 1'b0;
    logic             reset, start, abort, load;
    logic [WIDTH-1:0] load_val, target, cnt_q;
    logic             ff_clk, ff_reset;
    logic [WIDTH-1:0] ff_preset;
    logic             busy, done, error;
    logic [WIDTH-1:0] cur_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    controlador_contador_t #(
        .WIDTH(WIDTH), .PULSE_LOW(PL), .PULSE_HIGH(PH), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .load(load),
        .load_val(load_val), .target(target), .cnt_q(cnt_q),
        .ff_clk(ff_clk), .ff_reset(ff_reset), .ff_preset(ff_preset),
        .busy(busy), .done(done), .error(error), .cur_count(cur_count)
    );

    // Ripple bank seen as a whole: a falling ff_clk adds one, clear dominates preset.
    logic [WIDTH-1:0] bank       = '0;
    logic [WIDTH-1:0] stuck_mask = '0;
    logic             prev_clk   = 1'b1;
    int               falls      = 0;

    always @(ff_clk or ff_reset or ff_preset) begin
        if (ff_reset === 1'b1) begin
            bank = '0;
        end else begin
            if (^ff_preset !== 1'bx) bank = bank | ff_preset;
            if (prev_clk === 1'b1 && ff_clk === 1'b0) begin
                falls++;
                if (ff_preset === '0) bank = bank + 4'd1;
            end
        end
        prev_clk = ff_clk;
    end

    assign cnt_q = bank & ~stuck_mask;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_seq(input bit ld, input logic [WIDTH-1:0] lv,
                          input logic [WIDTH-1:0] tgt, input bit poke);
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] pre_val = '0;
        int  n = 0, exp_end, end_c = 0, done_c = -1, dones = 0;
        int  rst_cyc = 0, pre_cyc = 0, overlap = 0, f0;
        bit  exp_err = 1'b0, timeout = 1'b1;

        v = ld ? lv : '0;
        for (int i = 0; i <= 16; i++) begin
            if ((v & ~stuck_mask) != v) begin
                exp_err = 1'b1;
                break;
            end
            if (v == tgt) break;
            v = v + 4'd1;
            n++;
        end
        exp_end = 1 + (ld ? 1 : 0) + (SC + 1) + n * STEP + 2;

        @(negedge clk);
        start = 1'b1; load = ld; load_val = lv; target = tgt;
        f0 = falls;
        @(posedge clk);
        #1;
        start    = 1'b0;
        load     = 1'($urandom_range(0, 1));
        load_val = 4'($urandom);
        target   = 4'($urandom);
        for (int c = 1; c <= 400; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c == 1) check("err_clr", 32'(error), 32'(0));
            if (poke) start = (c == 3);
            if (ff_reset === 1'b1) rst_cyc++;
            if (ff_preset !== '0) begin
                pre_cyc++;
                pre_val = ff_preset;
            end
            if (ff_reset === 1'b1 && ff_preset !== '0) overlap++;
            if (done === 1'b1) begin
                dones++;
                done_c = c;
            end
            if (busy === 1'b0) begin
                end_c   = c;
                timeout = 1'b0;
                break;
            end
        end
        start = 1'b0;

        check("timeout",   32'(timeout), 32'(0));
        check("end_cycle", 32'(end_c),   32'(exp_end));
        check("falls",     32'(falls - f0), 32'(n));
        check("clr_cyc",   32'(rst_cyc), 32'(1));
        check("overlap",   32'(overlap), 32'(0));
        check("pre_cyc",   32'(pre_cyc), 32'((ld && lv != 0) ? 1 : 0));
        check("pre_val",   32'(pre_val), 32'(ld ? lv : 4'd0));
        check("dones",     32'(dones),   32'(exp_err ? 0 : 1));
        check("error",     32'(error),   32'(exp_err));
        check("cur_count", 32'(cur_count), 32'(v));
        if (!exp_err) begin
            check("done_cycle", 32'(done_c), 32'(exp_end - 1));
            check("cnt_q",      32'(cnt_q),  32'(tgt));
        end
    endtask

    task automatic do_abort(input bit use_reset);
        bit   found = 1'b0;
        int   f0, dones = 0;
        logic err_before;

        @(negedge clk);
        start = 1'b1; load = 1'b0; target = 4'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (ff_clk === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reach", 32'(found), 32'(1));
        f0         = falls;
        err_before = error;
        if (use_reset) reset = 1'b1;
        else           abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; abort = 1'b0; start = 1'b0;
        check("ab_ff_clk", 32'(ff_clk), 32'(1));
        check("ab_busy",   32'(busy),   32'(0));
        check("ab_done",   32'(done),   32'(0));
        check("ab_error",  32'(error),  32'(use_reset ? 1'b0 : err_before));
        if (use_reset) check("rst_cur", 32'(cur_count), 32'(0));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        check("ab_falls", 32'(falls - f0), 32'(0));
        check("ab_idle",  32'(busy),       32'(0));
        check("ab_nodone", 32'(dones),     32'(0));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; load = 1'b0;
        load_val = '0; target = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ff_clk",    32'(ff_clk),    32'(1));
        check("rst_ff_reset",  32'(ff_reset),  32'(0));
        check("rst_ff_preset", 32'(ff_preset), 32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_done",      32'(done),      32'(0));
        check("rst_error",     32'(error),     32'(0));
        check("rst_cur_count", 32'(cur_count), 32'(0));
        reset = 1'b0;

        do_seq(1'b0, 4'd0,  4'd5, 1'b1);
        do_seq(1'b1, 4'd14, 4'd1, 1'b0);
        do_seq(1'b1, 4'd7,  4'd7, 1'b0);

        stuck_mask = 4'b0100;
        do_seq(1'b0, 4'd0, 4'd6, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("err_held", 32'(error), 32'(1));
        stuck_mask = '0;
        do_seq(1'b0, 4'd0, 4'd3, 1'b0);

        do_abort(1'b0);
        do_abort(1'b1);

        for (int i = 0; i < 8; i++) begin
            do_seq(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
